// File: rtl/kb_entry_pkg.sv
// Shared types and helpers for the guess-entry buffer: FSM states, press event kinds,
// and a lowest-set-bit encoder used to turn a symbol key vector into a code.
package kb_entry_pkg;

    typedef enum logic [1:0] {
        ENTRY = 2'd0,
        FULL  = 2'd1,
        OFFER = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        EV_NONE = 2'd0,
        EV_SYM  = 2'd1,
        EV_DEL  = 2'd2,
        EV_ENT  = 2'd3
    } ev_t;

    localparam int MAX_SYMBOLS = 256;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic int lowest_set(input logic [MAX_SYMBOLS-1:0] vec);
        int idx;
        idx = 0;
        for (int i = MAX_SYMBOLS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/kb_press_detect.sv
// Turns held key levels into single press events (rising edge of "any key held")
// and decodes them by priority del > enter > lowest symbol index.
module kb_press_detect
    import kb_entry_pkg::*;
#(
    parameter int NUM_SYMBOLS = 8,
    parameter int CODE_W      = 3
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NUM_SYMBOLS-1:0] sym_key_i,
    input  logic                   del_key_i,
    input  logic                   ent_key_i,
    output ev_t                    ev_type_o,
    output logic [CODE_W-1:0]      ev_code_o
);

    logic                   any_now;
    logic                   any_prev_q;
    logic                   press;
    logic [MAX_SYMBOLS-1:0] sym_ext;

    assign any_now = (|sym_key_i) | del_key_i | ent_key_i;
    assign press   = any_now & ~any_prev_q;
    assign sym_ext = MAX_SYMBOLS'(sym_key_i);

    // Resetting to 1 makes a key held across reset look "already pressed".
    always_ff @(posedge clk) begin
        if (resetn) begin
            any_prev_q <= 1'b1;
        end else begin
            any_prev_q <= any_now;
        end
    end

    always_comb begin
        ev_type_o = EV_NONE;
        ev_code_o = CODE_W'(lowest_set(sym_ext));
        if (press) begin
            if (del_key_i) begin
                ev_type_o = EV_DEL;
            end else if (ent_key_i) begin
                ev_type_o = EV_ENT;
            end else begin
                ev_type_o = EV_SYM;
            end
        end
    end

endmodule

// File: rtl/kb_guess_entry.sv
// Multi-slot guess entry FSM: collects NUM_SLOTS symbol codes, supports delete/enter,
// and offers the finished guess over valid/ready. Define KB_ENTRY_NODUP_EN to refuse duplicate symbols.
module kb_guess_entry
    import kb_entry_pkg::*;
#(
    parameter int  NUM_SLOTS   = 4,
    parameter int  NUM_SYMBOLS = 8,
    parameter int  CODE_W      = 3,
    localparam int CNT_W       = $clog2(NUM_SLOTS + 1)
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_SYMBOLS-1:0]        sym_key,
    input  logic                          del_key,
    input  logic                          ent_key,
    output logic [NUM_SLOTS*CODE_W-1:0]   guess,
    output logic                          guess_valid,
    input  logic                          guess_ready,
    output logic [CNT_W-1:0]              slot_count,
    output logic                          reject
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               reject_q, reject_d;
    logic [CODE_W-1:0]  slot_q [NUM_SLOTS];
    logic [CODE_W-1:0]  slot_d [NUM_SLOTS];
    ev_t                ev_type;
    logic [CODE_W-1:0]  ev_code;
    logic               dup;

    kb_press_detect #(
        .NUM_SYMBOLS (NUM_SYMBOLS),
        .CODE_W      (CODE_W)
    ) u_press (
        .clk       (clk),
        .resetn    (resetn),
        .sym_key_i (sym_key),
        .del_key_i (del_key),
        .ent_key_i (ent_key),
        .ev_type_o (ev_type),
        .ev_code_o (ev_code)
    );

`ifdef KB_ENTRY_NODUP_EN
    always_comb begin
        dup = 1'b0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if ((CNT_W'(k) < count_q) && (slot_q[k] == ev_code)) begin
                dup = 1'b1;
            end
        end
    end
`else
    assign dup = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reject_d = 1'b0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            slot_d[k] = slot_q[k];
        end

        case (state_q)
            ENTRY: begin
                case (ev_type)
                    EV_SYM: begin
                        if (dup) begin
                            reject_d = 1'b1;
                        end else begin
                            for (int k = 0; k < NUM_SLOTS; k++) begin
                                if (CNT_W'(k) == count_q) begin
                                    slot_d[k] = ev_code;
                                end
                            end
                            count_d = count_q + 1'b1;
                            if (count_d == CNT_W'(NUM_SLOTS)) begin
                                state_d = FULL;
                            end
                        end
                    end
                    EV_DEL: begin
                        if (count_q == '0) begin
                            reject_d = 1'b1;
                        end else begin
                            count_d = count_q - 1'b1;
                            for (int k = 0; k < NUM_SLOTS; k++) begin
                                if (CNT_W'(k) == count_d) begin
                                    slot_d[k] = '0;
                                end
                            end
                        end
                    end
                    EV_ENT:  reject_d = 1'b1;
                    default: ;
                endcase
            end
            FULL: begin
                case (ev_type)
                    EV_SYM: reject_d = 1'b1;
                    EV_DEL: begin
                        count_d                = count_q - 1'b1;
                        slot_d[NUM_SLOTS-1]    = '0;
                        state_d                = ENTRY;
                    end
                    EV_ENT:  state_d = OFFER;
                    default: ;
                endcase
            end
            OFFER: begin
                // Presses are dropped silently while the guess is on offer.
                if (guess_ready) begin
                    for (int k = 0; k < NUM_SLOTS; k++) begin
                        slot_d[k] = '0;
                    end
                    count_d = '0;
                    state_d = ENTRY;
                end
            end
            default: state_d = ENTRY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q  <= ENTRY;
            count_q  <= '0;
            reject_q <= 1'b0;
            for (int k = 0; k < NUM_SLOTS; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reject_q <= reject_d;
            for (int k = 0; k < NUM_SLOTS; k++) begin
                slot_q[k] <= slot_d[k];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_pack
            assign guess[gi*CODE_W +: CODE_W] = slot_q[gi];
        end
    endgenerate

    assign guess_valid = (state_q == OFFER);
    assign slot_count  = count_q;
    assign reject      = reject_q;

endmodule

// File: tb/tb_kb_guess_entry.sv
// Directed bench for kb_guess_entry at default parameters; expectations are hand-computed.
module tb_kb_guess_entry;

    logic        clk;
    logic        resetn;
    logic [7:0]  sym_key;
    logic        del_key;
    logic        ent_key;
    logic [11:0] guess;
    logic        guess_valid;
    logic        guess_ready;
    logic [2:0]  slot_count;
    logic        reject;

    int checks;
    int failures;

    kb_guess_entry dut (
        .clk         (clk),
        .resetn      (resetn),
        .sym_key     (sym_key),
        .del_key     (del_key),
        .ent_key     (ent_key),
        .guess       (guess),
        .guess_valid (guess_valid),
        .guess_ready (guess_ready),
        .slot_count  (slot_count),
        .reject      (reject)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tap_sym(input int idx);
        sym_key = 8'(1 << idx);
        step();
    endtask

    task automatic release_all();
        sym_key = '0;
        del_key = 1'b0;
        ent_key = 1'b0;
        step();
    endtask

    task automatic status(input string tag, input logic [11:0] g, input logic [2:0] cnt,
                          input logic v, input logic rj);
        $display("%s guess=0x%03h count=%0d valid=%0b reject=%0b", tag, guess, slot_count,
                 guess_valid, reject);
        chk({tag, ".guess"}, 32'(guess), 32'(g));
        chk({tag, ".count"}, 32'(slot_count), 32'(cnt));
        chk({tag, ".valid"}, 32'(guess_valid), 32'(v));
        chk({tag, ".reject"}, 32'(reject), 32'(rj));
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        resetn      = 1'b1;
        sym_key     = 8'h10;
        del_key     = 1'b0;
        ent_key     = 1'b0;
        guess_ready = 1'b0;

        // Sym 4 held through reset release.
        step();
        step();
        status("reset", 12'h000, 3'd0, 1'b0, 1'b0);
        resetn = 1'b0;
        step();
        step();
        status("held_after_reset", 12'h000, 3'd0, 1'b0, 1'b0);
        release_all();
        status("held_released", 12'h000, 3'd0, 1'b0, 1'b0);

        // Enter 3,5,0,7.
        tap_sym(3);
        status("sym3", 12'h003, 3'd1, 1'b0, 1'b0);
        release_all();
        tap_sym(5);
        status("sym5", 12'h02B, 3'd2, 1'b0, 1'b0);
        release_all();
        tap_sym(0);
        status("sym0", 12'h02B, 3'd3, 1'b0, 1'b0);
        release_all();
        tap_sym(7);
        status("sym7", 12'hE2B, 3'd4, 1'b0, 1'b0);
        release_all();

        // Symbol while full is refused.
        tap_sym(1);
        status("full_sym", 12'hE2B, 3'd4, 1'b0, 1'b1);
        release_all();
        status("full_sym_rel", 12'hE2B, 3'd4, 1'b0, 1'b0);

        ent_key = 1'b1;
        step();
        status("enter", 12'hE2B, 3'd4, 1'b1, 1'b0);
        ent_key = 1'b0;

        // Stall the consumer; a press during offer is dropped silently.
        for (int i = 0; i < 10; i++) begin
            if (i == 3) sym_key = 8'h02;
            if (i == 5) sym_key = 8'h00;
            step();
            status("offer_hold", 12'hE2B, 3'd4, 1'b1, 1'b0);
        end
        guess_ready = 1'b1;
        step();
        guess_ready = 1'b0;
        status("accept", 12'h000, 3'd0, 1'b0, 1'b0);

        // Delete from empty is refused.
        del_key = 1'b1;
        step();
        status("del_empty", 12'h000, 3'd0, 1'b0, 1'b1);
        release_all();
        status("del_empty_rel", 12'h000, 3'd0, 1'b0, 1'b0);

        tap_sym(6);
        status("sym6", 12'h006, 3'd1, 1'b0, 1'b0);
        release_all();
        tap_sym(1);
        status("sym1", 12'h00E, 3'd2, 1'b0, 1'b0);
        release_all();
        ent_key = 1'b1;
        step();
        status("enter_partial", 12'h00E, 3'd2, 1'b0, 1'b1);
        release_all();

        del_key = 1'b1;
        step();
        status("del_one", 12'h006, 3'd1, 1'b0, 1'b0);
        release_all();

        // Two symbols in one press: lowest index wins; a late key while held is ignored.
        sym_key = 8'b0010_0100;
        step();
        status("multi_sym", 12'h016, 3'd2, 1'b0, 1'b0);
        sym_key = 8'b0110_0100;
        step();
        status("late_key", 12'h016, 3'd2, 1'b0, 1'b0);
        release_all();
        status("late_key_rel", 12'h016, 3'd2, 1'b0, 1'b0);

        // Reset mid-entry discards the partial guess.
        resetn = 1'b1;
        step();
        status("reset_mid", 12'h000, 3'd0, 1'b0, 1'b0);
        resetn = 1'b0;
        step();

        tap_sym(1);
        status("dup_first", 12'h001, 3'd1, 1'b0, 1'b0);
        release_all();
        tap_sym(1);
`ifdef KB_ENTRY_NODUP_EN
        status("dup_second", 12'h001, 3'd1, 1'b0, 1'b1);
`else
        status("dup_second", 12'h009, 3'd2, 1'b0, 1'b0);
`endif
        release_all();

        // Delete from FULL returns to ENTRY and entry resumes.
        resetn = 1'b1;
        step();
        resetn = 1'b0;
        step();
        tap_sym(0);
        release_all();
        tap_sym(1);
        release_all();
        tap_sym(2);
        release_all();
        tap_sym(3);
        status("fill2", 12'h688, 3'd4, 1'b0, 1'b0);
        release_all();
        del_key = 1'b1;
        step();
        status("full_del", 12'h088, 3'd3, 1'b0, 1'b0);
        release_all();
        tap_sym(7);
        status("refill", 12'hE88, 3'd4, 1'b0, 1'b0);
        release_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/kb_guess_entry.md
# kb_guess_entry

Parametrised guess-entry buffer between the PS/2 keyboard tracker and the game core. It turns per-key level signals into single press events and assembles NUM_SLOTS symbol codes into one guess word, with delete and enter keys. The completed guess goes to the scoring logic over a valid/ready handshake. It replaces the fixed 5-bit priority mux with an event-driven, multi-slot entry state machine.

## Interface
- NUM_SLOTS, 4: symbols per guess, ≥1.
- NUM_SYMBOLS, 8: symbol keys, ≥2.
- CODE_W, 3: bits per slot code, ≥ $clog2(NUM_SYMBOLS).
- CNT_W, $clog2(NUM_SLOTS+1): slot counter width (derived, not overridden).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- resetn  in  1  synchronous, active-high reset. The port name follows codebase naming; the polarity is high.
- sym_key  in  NUM_SYMBOLS  level, bit i high while symbol key i is held.
- del_key  in  1  level, delete key held.
- ent_key  in  1  level, enter key held.
- guess  out  NUM_SLOTS*CODE_W  slot k at bits [k*CODE_W +: CODE_W]; slot 0 is the first entered.
- guess_valid  out  1  completed guess offered.
- guess_ready  in  1  consumer accepts the guess.
- slot_count  out  CNT_W  number of filled slots, for display.
- reject  out  1  one-cycle pulse when a press is refused.

## Operation
- Press detection: any_now = |{sym_key, del_key, ent_key}. A registered any_prev tracks it. A press event occurs when any_now=1 and any_prev=0.
  - Further keys pressed while another key is held are ignored until all keys are released.
- Event decode priority: del_key > ent_key > lowest set sym_key index. Symbol code = index, zero-extended to CODE_W.
- States:
  - ENTRY (reset state)
    - symbol: write the code to slot[slot_count] and increment slot_count. Go to FULL when the new count = NUM_SLOTS.
    - del: decrement slot_count. The vacated slot is zeroed. If slot_count=0, assert reject and change nothing.
    - enter: assert reject and change nothing.
  - FULL
    - symbol: reject.
    - del: decrement slot_count, zero the last slot, go to ENTRY.
    - enter: go to OFFER.
  - OFFER
    - guess_valid=1. guess and slot_count are held stable.
    - All press events are ignored silently (no reject).
    - On guess_valid & guess_ready: zero all slots, set slot_count=0, go to ENTRY.
- Reset values: guess=0, guess_valid=0, slot_count=0, reject=0, state=ENTRY.
  - any_prev resets to 1, so a key held through reset is not accepted until it is released.
- Reset mid-entry or mid-offer discards the partial or offered guess immediately.

## Timing
- A press sampled at edge t updates guess and slot_count at edge t. The result is visible in the cycle after t. reject is high for the cycle after t only.
- guess_valid rises the cycle after the enter press is sampled.
- guess_valid stays high until a cycle with guess_ready=1. The handshake completes at that edge, and guess_valid=0 in the next cycle. Zero-bubble acceptance is allowed.
- guess_ready outside OFFER has no effect.
- Throughput: at most one press event per release/press pair. A press needs ≥1 cycle with all keys low before it.

## Configuration
- KB_ENTRY_NODUP_EN defined: a symbol press whose code equals any filled slot asserts reject and writes nothing. This applies in ENTRY; in FULL symbols are rejected anyway.
- Undefined: duplicate symbols are accepted like any other symbol.

## Structure
- Package kb_entry_pkg holds:
  - the state enum (ENTRY, FULL, OFFER);
  - the event enum (EV_NONE, EV_SYM, EV_DEL, EV_ENT);
  - a lowest-set-bit encode function.
- Sub-module kb_press_detect: holds any_prev and the reset-to-1 behaviour, decodes priority, and outputs ev_type plus ev_code (CODE_W). kb_guess_entry contains the FSM and the slot buffer.

## Test plan
Defaults: NUM_SLOTS=4, NUM_SYMBOLS=8, CODE_W=3.
- Press and release sym 3, 5, 0, 7, then enter → guess=12'b111_000_101_011, guess_valid=1 the cycle after enter; slot_count=4.
- Hold guess_ready=0 for 10 cycles, then 1 → guess stable throughout; slot_count=0 and guess_valid=0 the cycle after acceptance.
- From empty, press del; then press enter with 2 slots filled → reject pulses once each; slot_count unchanged (0, then 2).
- Hold sym_key=8'b0010_0100 as one press → code 2 written. Press sym 6 while sym 2 is still held → ignored.
- Hold sym 4 through reset deassertion → nothing written until release; the next press writes normally.
- With KB_ENTRY_NODUP_EN: enter 1, 1 → the second press rejects and slot_count stays 1. Without the macro → slot_count=2, guess[5:0]=6'b001_001.
